// File: rtl/cnn_zero_pad_stream.sv
// Streaming zero-pad stage: wraps each IMAGE_WIDTH x IMAGE_HEIGHT map of a channel-major raster
// stream in PAD rows/columns of zeros, stalling upstream while border zeros are emitted.
module cnn_zero_pad_stream #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned IMAGE_WIDTH  = 153,
    parameter int unsigned IMAGE_HEIGHT = 153,
    parameter int unsigned CHANNEL_NUM  = 64,
    parameter int unsigned PAD          = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] pxl_in,
    output logic                  ready_in,
    output logic [DATA_WIDTH-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_done
);

    localparam int unsigned PW = IMAGE_WIDTH + 2 * PAD;
    localparam int unsigned PH = IMAGE_HEIGHT + 2 * PAD;
    localparam int unsigned CW = (PW > 1) ? $clog2(PW) : 1;
    localparam int unsigned RW = (PH > 1) ? $clog2(PH) : 1;
    localparam int unsigned HW = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(PW - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(PH - 1);
    localparam logic [HW-1:0] CH_LAST  = HW'(CHANNEL_NUM - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e        state_q;
    logic [CW-1:0] col_q;
    logic [RW-1:0] row_q;
    logic [HW-1:0] ch_q;

    logic [31:0] col_x;
    logic [31:0] row_x;
    logic        interior;
    logic        advance;
    logic        col_end;
    logic        row_end;
    logic        ch_end;

    always_comb begin
        col_x    = 32'(col_q);
        row_x    = 32'(row_q);
        // "x + 1 > PAD" is the lower bound; it stays meaningful when PAD is 0.
        interior = (col_x + 32'd1 > PAD) && (col_x < PAD + IMAGE_WIDTH) &&
                   (row_x + 32'd1 > PAD) && (row_x < PAD + IMAGE_HEIGHT);
        col_end  = (col_q == COL_LAST);
        row_end  = (row_q == ROW_LAST);
        ch_end   = (ch_q == CH_LAST);
        ready_in = (state_q == StRun) && interior;
        // Border positions advance unconditionally; interior ones wait for a pixel.
        advance  = (state_q == StRun) && (!interior || valid_in);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            pxl_out    <= '0;
            valid_out  <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state_q)
                StIdle: begin
                    valid_out <= 1'b0;
                    if (valid_in) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    valid_out <= advance;
                    if (advance) begin
                        pxl_out <= interior ? pxl_in : '0;
                        if (!col_end) begin
                            col_q <= col_q + 1'b1;
                        end else begin
                            col_q <= '0;
                            if (!row_end) begin
                                row_q <= row_q + 1'b1;
                            end else begin
                                row_q <= '0;
                                if (ch_end) begin
                                    ch_q       <= '0;
                                    frame_done <= 1'b1;
                                    state_q    <= StIdle;
                                end else begin
                                    ch_q <= ch_q + 1'b1;
                                end
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
